// File: rtl/dot_bias_pipe.sv
// Pipelined signed fixed-point dot product plus bias with round/saturate
// and a credit-counted FWFT output FIFO so downstream stalls never drop results.
module dot_bias_pipe #(
    parameter int N_TERMS    = 4,
    parameter int DATA_W     = 16,
    parameter int FRAC_W     = 8,
    parameter int OUT_W      = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        ivalid,
    output logic                        oready,
    input  logic [N_TERMS*DATA_W-1:0]   datain_a,
    input  logic [N_TERMS*DATA_W-1:0]   datain_b,
    input  logic [DATA_W-1:0]           datain_c,
    output logic                        ovalid,
    input  logic                        iready,
    output logic [OUT_W-1:0]            dataout,
    output logic                        osat
);
    localparam int LVLS  = $clog2(N_TERMS);
    localparam int LAT   = 4 + LVLS;
    localparam int SUM_W = 2 * DATA_W + LVLS + 2;
    localparam int ACC_W = (SUM_W > OUT_W + FRAC_W + 1) ? SUM_W : OUT_W + FRAC_W + 1;
    localparam int RND_W = ACC_W - FRAC_W;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic signed [RND_W-1:0] SAT_MAX = {{(RND_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [RND_W-1:0] SAT_MIN = ~SAT_MAX;

    logic accept;
    logic pop;
    logic push;

    logic signed [DATA_W-1:0] a_reg    [N_TERMS];
    logic signed [DATA_W-1:0] b_reg    [N_TERMS];
    logic signed [DATA_W-1:0] c_reg    [LVLS+2];
    logic signed [ACC_W-1:0]  tree_reg [LVLS+1][N_TERMS];
    logic signed [ACC_W-1:0]  bias_reg;
    logic signed [ACC_W-1:0]  rnd_sum;
    logic signed [RND_W-1:0]  rnd_val;
    logic [OUT_W-1:0]         res_next;
    logic                     sat_next;
    logic [OUT_W-1:0]         res_reg;
    logic                     sat_reg;
    logic [LAT-1:0]           valid_reg;

    logic [OUT_W:0]           fifo_mem [FIFO_DEPTH];
    logic [OUT_W:0]           fifo_head;
    logic [PTR_W-1:0]         wr_ptr_reg;
    logic [PTR_W-1:0]         rd_ptr_reg;
    logic [CNT_W-1:0]         fifo_cnt_reg;
    logic [CNT_W-1:0]         cnt_reg;

    function automatic int lane_idx(input int x);
        return (x < N_TERMS) ? x : N_TERMS - 1;
    endfunction

    assign oready = (cnt_reg < CNT_W'(FIFO_DEPTH)) && !reset;
    assign accept = ivalid && oready;
    assign ovalid = (fifo_cnt_reg != '0);
    assign pop    = ovalid && iready;
    assign push   = valid_reg[LAT-1];

    // One valid bit per stage; the data path itself never stalls.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_reg <= '0;
        end else begin
            valid_reg <= {valid_reg[LAT-2:0], accept};
        end
    end

    // Inputs are captured only on accept so idle-bus garbage never enters the datapath.
    always_ff @(posedge clock) begin
        if (accept) begin
            c_reg[0] <= datain_c;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_TERMS; gi++) begin : g_lane
            always_ff @(posedge clock) begin
                if (accept) begin
                    a_reg[gi] <= datain_a[gi*DATA_W +: DATA_W];
                    b_reg[gi] <= datain_b[gi*DATA_W +: DATA_W];
                end
                tree_reg[0][gi] <= ACC_W'(a_reg[gi]) * ACC_W'(b_reg[gi]);
            end
        end

        always_ff @(posedge clock) begin
            c_reg[1] <= c_reg[0];
        end

        // Binary adder tree; an odd trailing node is passed through unchanged.
        for (gi = 1; gi <= LVLS; gi++) begin : g_lvl
            localparam int PREV = (N_TERMS + (1 << (gi - 1)) - 1) >> (gi - 1);
            always_ff @(posedge clock) begin
                for (int j = 0; j < N_TERMS; j++) begin
                    if (2 * j + 1 < PREV) begin
                        tree_reg[gi][j] <= tree_reg[gi-1][lane_idx(2*j)] + tree_reg[gi-1][lane_idx(2*j+1)];
                    end else if (2 * j < PREV) begin
                        tree_reg[gi][j] <= tree_reg[gi-1][lane_idx(2*j)];
                    end else begin
                        tree_reg[gi][j] <= '0;
                    end
                end
                c_reg[gi+1] <= c_reg[gi];
            end
        end
    endgenerate

    // Bias is shifted up to the 2*FRAC_W scale of the products.
    always_ff @(posedge clock) begin
        bias_reg <= tree_reg[LVLS][0] + (ACC_W'(c_reg[LVLS+1]) <<< FRAC_W);
    end

    always_comb begin
        rnd_sum  = bias_reg + (ACC_W'(1) <<< (FRAC_W - 1));
        rnd_val  = rnd_sum[ACC_W-1:FRAC_W];
        res_next = rnd_val[OUT_W-1:0];
        sat_next = 1'b0;
        if (rnd_val > SAT_MAX) begin
            res_next = SAT_MAX[OUT_W-1:0];
            sat_next = 1'b1;
        end else if (rnd_val < SAT_MIN) begin
            res_next = SAT_MIN[OUT_W-1:0];
            sat_next = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        res_reg <= res_next;
        sat_reg <= sat_next;
    end

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= {sat_reg, res_reg};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            fifo_cnt_reg <= '0;
            cnt_reg      <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= (wr_ptr_reg == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= (rd_ptr_reg == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_cnt_reg <= fifo_cnt_reg + CNT_W'(1);
                2'b01:   fifo_cnt_reg <= fifo_cnt_reg - CNT_W'(1);
                default: fifo_cnt_reg <= fifo_cnt_reg;
            endcase
            // Credits cover every beat between acceptance and pop, so the FIFO cannot overflow.
            case ({accept, pop})
                2'b10:   cnt_reg <= cnt_reg + CNT_W'(1);
                2'b01:   cnt_reg <= cnt_reg - CNT_W'(1);
                default: cnt_reg <= cnt_reg;
            endcase
        end
    end

    assign fifo_head = fifo_mem[rd_ptr_reg];
    assign dataout   = ovalid ? fifo_head[OUT_W-1:0] : '0;
    assign osat      = ovalid ? fifo_head[OUT_W] : 1'b0;

endmodule

// File: tb/tb_dot_bias_pipe.sv
// Scoreboard bench for dot_bias_pipe: driver pushes expected results on accept,
// an independent monitor pops and compares on every output handshake.
module tb_dot_bias_pipe;
    localparam int N = 4;
    localparam int DW = 16;
    localparam int FW = 8;
    localparam int OW = 16;

    typedef struct packed {
        logic [OW-1:0] d;
        logic          s;
        logic [31:0]   id;
    } exp_t;

    logic              clock = 1'b0;
    logic              reset;
    logic              ivalid;
    logic              oready;
    logic [N*DW-1:0]   datain_a;
    logic [N*DW-1:0]   datain_b;
    logic [DW-1:0]     datain_c;
    logic              ovalid;
    logic              iready;
    logic signed [OW-1:0] dataout;
    logic              osat;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_acc_cyc = 0;
    int acc_count = 0;
    int stall_cycles = 0;
    exp_t sb[$];

    logic          hold_valid = 1'b0;
    logic [OW-1:0] hold_d;
    logic          hold_s;

    dot_bias_pipe #(.N_TERMS(N), .DATA_W(DW), .FRAC_W(FW), .OUT_W(OW), .FIFO_DEPTH(8)) dut (
        .clock(clock), .reset(reset), .ivalid(ivalid), .oready(oready),
        .datain_a(datain_a), .datain_b(datain_b), .datain_c(datain_c),
        .ovalid(ovalid), .iready(iready), .dataout(dataout), .osat(osat)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    function automatic logic [N*DW-1:0] pack4(input int x0, input int x1, input int x2, input int x3);
        logic [N*DW-1:0] v;
        v = {DW'(x3), DW'(x2), DW'(x1), DW'(x0)};
        return v;
    endfunction

    // Reference: exact 64-bit arithmetic, then round half up and clip.
    function automatic exp_t model(input logic [N*DW-1:0] av, input logic [N*DW-1:0] bv,
                                   input logic [DW-1:0] cv, input int id);
        longint s;
        longint r;
        exp_t e;
        s = 0;
        for (int i = 0; i < N; i++) begin
            s += longint'($signed(av[i*DW +: DW])) * longint'($signed(bv[i*DW +: DW]));
        end
        s += longint'($signed(cv)) * (longint'(1) << FW);
        r = (s + (longint'(1) << (FW - 1))) >>> FW;
        e.s = 1'b0;
        if (r > 32767) begin
            r = 32767;
            e.s = 1'b1;
        end else if (r < -32768) begin
            r = -32768;
            e.s = 1'b1;
        end
        e.d = OW'(r);
        e.id = id;
        return e;
    endfunction

    task automatic send(input logic [N*DW-1:0] av, input logic [N*DW-1:0] bv,
                        input logic [DW-1:0] cv, input int exp_d, input logic exp_s, input int id);
        int w;
        exp_t e;
        w = 0;
        datain_a = av;
        datain_b = bv;
        datain_c = cv;
        ivalid = 1'b1;
        while (1) begin
            @(negedge clock);
            if (oready) break;
            w++;
            stall_cycles++;
            if (w > 300) begin
                check($sformatf("accept_timeout_id%0d", id), 0, 1);
                break;
            end
        end
        if (oready) begin
            e.d = OW'(exp_d);
            e.s = exp_s;
            e.id = id;
            sb.push_back(e);
            last_acc_cyc = cyc + 1;
            acc_count++;
        end
        @(posedge clock);
        #1;
        ivalid = 1'b0;
        datain_a = {$urandom, $urandom};
        datain_b = {$urandom, $urandom};
        datain_c = DW'($urandom);
    endtask

    task automatic send_model(input logic [N*DW-1:0] av, input logic [N*DW-1:0] bv,
                              input logic [DW-1:0] cv, input int id);
        exp_t e;
        e = model(av, bv, cv, id);
        send(av, bv, cv, int'($signed(e.d)), e.s, id);
    endtask

    function automatic logic [N*DW-1:0] rnd_vec();
        logic [N*DW-1:0] v;
        for (int i = 0; i < N; i++) v[i*DW +: DW] = DW'(int'($urandom_range(0, 4095)) - 2048);
        return v;
    endfunction

    task automatic drain(input string name);
        int k;
        k = 0;
        while (sb.size() != 0 && k < 500) begin
            @(negedge clock);
            k++;
        end
        check({name, "_drain_left"}, sb.size(), 0);
        repeat (8) @(negedge clock);
        @(posedge clock);
        #1;
    endtask

    task automatic wait_latency(input string name);
        int k;
        for (k = 0; k < 20; k++) begin
            @(negedge clock);
            if (ovalid) break;
        end
        check({name, "_latency"}, cyc - last_acc_cyc, 6);
    endtask

    // Monitor: compares on every pop, flags unexpected output and unstable stalled data.
    always @(negedge clock) begin
        exp_t e;
        if (reset) begin
            hold_valid <= 1'b0;
        end else if (ovalid) begin
            if (sb.size() == 0) begin
                check("unexpected_output", 1, 0);
            end else if (iready) begin
                e = sb.pop_front();
                check($sformatf("data_id%0d", e.id), int'(dataout), int'($signed(e.d)));
                check($sformatf("sat_id%0d", e.id), int'(osat), int'(e.s));
                $display("result id=%0d dataout=%0d osat=%0d", e.id, dataout, osat);
                hold_valid <= 1'b0;
            end else begin
                if (hold_valid) begin
                    check("stall_hold_data", int'(dataout), int'($signed(hold_d)));
                    check("stall_hold_sat", int'(osat), int'(hold_s));
                end
                hold_valid <= 1'b1;
                hold_d <= dataout;
                hold_s <= osat;
            end
        end else begin
            hold_valid <= 1'b0;
        end
    end

    initial begin
        int base;
        int t0;
        reset = 1'b1;
        ivalid = 1'b0;
        iready = 1'b1;
        datain_a = '0;
        datain_b = '0;
        datain_c = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset_oready", int'(oready), 0);
        check("reset_ovalid", int'(ovalid), 0);
        check("reset_dataout", int'(dataout), 0);
        check("reset_osat", int'(osat), 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("post_reset_oready", int'(oready), 1);
        check("post_reset_ovalid", int'(ovalid), 0);
        @(posedge clock);
        #1;

        // Basic: 3.5 with exact six-cycle latency
        send(pack4(256, 256, 256, 256), pack4(512, 256, -256, 128), 16'd256, 896, 1'b0, 1);
        wait_latency("basic");
        drain("basic");

        // Rounding, a mixed-sign vector and saturation, all hand-computed
        send(pack4(1, 0, 0, 0), pack4(128, 0, 0, 0), 16'd0, 1, 1'b0, 2);
        send(pack4(-1, 0, 0, 0), pack4(128, 0, 0, 0), 16'd0, 0, 1'b0, 3);
        send(pack4(-1, 0, 0, 0), pack4(129, 0, 0, 0), 16'd0, -1, 1'b0, 4);
        send(pack4(384, 0, 0, 0), pack4(-640, 0, 0, 0), -16'sd256, -1216, 1'b0, 5);
        send(pack4(32767, 32767, 32767, 32767), pack4(32767, 32767, 32767, 32767), 16'd32767, 32767, 1'b1, 6);
        send(pack4(-32768, -32768, -32768, -32768), pack4(32767, 32767, 32767, 32767), 16'd0, -32768, 1'b1, 7);
        drain("directed");

        // Backpressure: downstream stalled for 15 cycles
        base = acc_count;
        fork
            begin
                for (int i = 0; i < 20; i++) send_model(rnd_vec(), rnd_vec(), DW'($urandom_range(0, 4095) - 2048), 100 + i);
            end
            begin
                iready = 1'b0;
                repeat (15) @(negedge clock);
                check("stall_accepted", acc_count - base, 8);
                check("stall_oready", int'(oready), 0);
                @(posedge clock);
                #1;
                iready = 1'b1;
            end
        join
        drain("stall");

        // Full rate: 100 back-to-back beats
        stall_cycles = 0;
        t0 = cyc + 1;
        for (int i = 0; i < 100; i++) send_model(rnd_vec(), rnd_vec(), DW'($urandom_range(0, 4095) - 2048), 200 + i);
        while (sb.size() != 0 && cyc < t0 + 400) @(negedge clock);
        check("fullrate_stalls", stall_cycles, 0);
        checks++;
        if (cyc - t0 > 106) begin
            errors++;
            $display("FAIL fullrate_span: got %0d cycles required at most 106", cyc - t0);
        end
        drain("fullrate");

        // Reset with five beats in flight; nothing stale may appear afterwards
        for (int i = 0; i < 5; i++) send_model(rnd_vec(), rnd_vec(), 16'd100, 400 + i);
        reset = 1'b1;
        sb.delete();
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("midreset_ovalid", int'(ovalid), 0);
        check("midreset_dataout", int'(dataout), 0);
        check("midreset_oready", int'(oready), 1);
        repeat (12) @(negedge clock);
        @(posedge clock);
        #1;
        send(pack4(256, 256, 256, 256), pack4(512, 256, -256, 128), 16'd256, 896, 1'b0, 500);
        wait_latency("after_reset");
        drain("after_reset");

        check("final_queue_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
